data_distributor_seq: RTL and testbench
=======================================

// Module: data_distributor_seq
// PURPOSE
//  Registered, parametrised successor of the 1-to-8 data distributor (demux).
//  Routes each accepted input word to one of CH output channels, and holds the
//  last word per channel. Routing is either addressed (sel) or auto round-robin
//  scan over enabled channels. Sits between a single word source and CH
//  consumers such as LED/seven-segment lanes or per-channel registers.
// PARAMETERS
//  WIDTH  8  data word width in bits
//  SEL_W  3  channel index width; CH = 1<<SEL_W channels (default 8)
//  CNT_W  16 width of the accepted-word counter
// PORTS
//  clk         in   1          rising-edge clock, single clock domain
//  rst         in   1          synchronous reset, active-high
//  mode        in   1          0 = addressed (use sel); 1 = round-robin scan
//  sel         in   SEL_W      target channel in addressed mode
//  ch_en       in   CH         per-channel enable mask; bit i = channel i
//  clear       in   1          synchronous clear of all held channel words
//  in_data     in   WIDTH      input word
//  in_valid    in   1          input word valid
//  in_ready    out  1          block can accept this cycle (combinational)
//  out_data    out  CH*WIDTH   held word per channel; ch i = [i*WIDTH +: WIDTH]
//  out_strobe  out  CH         one-hot, one-cycle pulse: channel i updated
//  cur_ch      out  SEL_W      scan pointer: next channel in scan mode
//  word_cnt    out  CNT_W      total accepted words, wraps to 0 at overflow
// BEHAVIOUR
//  - Reset: clk and rst only; rst is synchronous, active-high, highest priority.
//    After reset: out_data=0, out_strobe=0, cur_ch=0, word_cnt=0.
//  - Target t = mode ? cur_ch : sel. in_ready = ch_en[t] & ~rst.
//  - Accept = in_valid & in_ready. The next cycle after accept:
//    out_data[t]=in_data; out_strobe=onehot(t); word_cnt+1. Latency is 1 cycle.
//  - out_strobe is 0 in every cycle that does not follow an accept. Other
//    channels' out_data hold their value.
//  - in_valid with in_ready=0 (target channel disabled): the word is stalled,
//    not dropped. Nothing changes except the scan pointer rule below.
//  - Scan pointer (registered):
//    - Scan-mode accept: cur_ch = first enabled channel, searched circularly
//      from t+1 (CH-1 wraps to 0). If t is the only enabled channel, cur_ch=t.
//    - cur_ch disabled and no accept: cur_ch advances to the first enabled
//      channel from cur_ch+1, circularly, in 1 cycle.
//    - ch_en all zero: cur_ch holds, and in_ready=0 in both modes.
//    - Addressed mode: cur_ch does not change, except by the disabled-pointer
//      rule above.
//  - mode and sel are sampled every cycle. A mode switch takes effect on the
//    same cycle and keeps cur_ch.
//  - clear: all out_data go to 0 on the next cycle. If clear and accept fall in
//    the same cycle, channel t loads in_data, all other channels clear, and the
//    strobe is still emitted. clear does not affect cur_ch or word_cnt.
//  - Reset mid-stream: a word presented in the rst cycle is not accepted. No
//    strobe follows, and the state is the reset state.
//  - word_cnt wraps from 2^CNT_W-1 to 0, with no flag.
// TESTING
//  1 Reset: rst=1 for 2 cycles with in_valid=1 -> out_data=0, out_strobe=0,
//    cur_ch=0, word_cnt=0, in_ready=0 during rst.
//  2 Addressed: mode=0, ch_en=8'hFF, sel=5, in_data=8'hA5, 1 cycle ->
//    next cycle out_strobe=8'h20, ch5=8'hA5, other channels 0, word_cnt=1.
//  3 Scan wrap: mode=1, ch_en=8'hFF, 9 words 1..9 back-to-back ->
//    ch0..ch7 = 1..8, then ch0 = 9, cur_ch=1, word_cnt=9.
//  4 Mask skip: mode=1, ch_en=8'b1000_0101, words 8'h11,8'h22,8'h33,8'h44 ->
//    strobes land on ch0,ch2,ch7,ch0 in that order.
//  5 Stall and empty mask: mode=0, sel=3, ch_en[3]=0, in_valid=1 -> in_ready=0
//    and no strobe; after setting ch_en[3]=1 -> accepted next cycle.
//    ch_en=0 in scan mode -> in_ready=0 and cur_ch held.
//  6 Clear plus accept: ch1..ch7 hold nonzero; clear=1 with an addressed
//    accept sel=2, data 8'h3C -> ch2=8'h3C, all other channels 0,
//    out_strobe=8'h04.

Source files
------------

// File: rtl/data_distributor_seq.sv
// Registered 1-to-CH data distributor: routes accepted words to an addressed or
// round-robin-scanned channel and holds the last word seen on every channel.
module data_distributor_seq #(
  parameter  int WIDTH = 8,
  parameter  int SEL_W = 3,
  parameter  int CNT_W = 16,
  localparam int CH    = 1 << SEL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [CH-1:0]       ch_en,
  input  logic                clear,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CH*WIDTH-1:0] out_data,
  output logic [CH-1:0]       out_strobe,
  output logic [SEL_W-1:0]    cur_ch,
  output logic [CNT_W-1:0]    word_cnt
);

  logic [SEL_W-1:0]    target_s;
  logic                ready_s;
  logic                accept_s;
  logic                any_en_s;
  logic [SEL_W-1:0]    cur_ch_r;
  logic [SEL_W-1:0]    cur_ch_s;
  logic [CH*WIDTH-1:0] out_data_r;
  logic [CH*WIDTH-1:0] out_data_s;
  logic [CH-1:0]       out_strobe_r;
  logic [CH-1:0]       out_strobe_s;
  logic [CNT_W-1:0]    word_cnt_r;
  logic [CNT_W-1:0]    word_cnt_s;

  // First enabled channel strictly after 'from', circularly; the last probe
  // lands back on 'from', so a lone enabled channel selects itself.
  function automatic logic [SEL_W-1:0] next_enabled(
    input logic [CH-1:0]    en,
    input logic [SEL_W-1:0] from
  );
    logic [SEL_W-1:0] idx;
    logic             found;
    next_enabled = from;
    found        = 1'b0;
    for (int k = 1; k <= CH; k++) begin
      idx = from + k[SEL_W-1:0];
      if (!found && en[idx]) begin
        next_enabled = idx;
        found        = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Target selection and handshake
  always_comb begin
    target_s = mode ? cur_ch_r : sel;
    any_en_s = |ch_en;
    ready_s  = ch_en[target_s] & ~rst;
    accept_s = in_valid & ready_s;
  end

  // Next-state for held words, strobe, counter and scan pointer
  always_comb begin
    out_data_s   = out_data_r;
    out_strobe_s = '0;
    word_cnt_s   = word_cnt_r;
    cur_ch_s     = cur_ch_r;

    if (clear) begin
      out_data_s = '0;
    end else begin
      out_data_s = out_data_r;
    end

    if (accept_s) begin
      out_data_s[int'(target_s)*WIDTH +: WIDTH] = in_data;
      out_strobe_s[target_s]                    = 1'b1;
      word_cnt_s                                = word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      word_cnt_s = word_cnt_r;
    end

    // A disabled pointer is pushed forward even in addressed mode
    if (mode && accept_s) begin
      cur_ch_s = next_enabled(ch_en, target_s);
    end else if (any_en_s && !ch_en[cur_ch_r]) begin
      cur_ch_s = next_enabled(ch_en, cur_ch_r);
    end else begin
      cur_ch_s = cur_ch_r;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r   <= '0;
      out_strobe_r <= '0;
      word_cnt_r   <= '0;
      cur_ch_r     <= '0;
    end else begin
      out_data_r   <= out_data_s;
      out_strobe_r <= out_strobe_s;
      word_cnt_r   <= word_cnt_s;
      cur_ch_r     <= cur_ch_s;
    end
  end

  assign in_ready   = ready_s;
  assign out_data   = out_data_r;
  assign out_strobe = out_strobe_r;
  assign cur_ch     = cur_ch_r;
  assign word_cnt   = word_cnt_r;

endmodule

// File: tb/tb_data_distributor_seq.sv
// Self-checking bench for data_distributor_seq: directed scenarios plus
// randomized traffic against a queue-free behavioural channel model.
module tb_data_distributor_seq;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  ch_en;
  logic        clear;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_strobe;
  logic [2:0]  cur_ch;
  logic [15:0] word_cnt;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [7:0]  m_data [8];
  logic [7:0]  m_strobe;
  int          m_ptr;
  logic [15:0] m_cnt;

  data_distributor_seq #(.WIDTH(8), .SEL_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .ch_en(ch_en),
    .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_strobe(out_strobe),
    .cur_ch(cur_ch), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int mdl_next(input logic [7:0] en, input int from);
    for (int k = 1; k <= 8; k++) begin
      if (en[(from + k) % 8]) return (from + k) % 8;
    end
    return from;
  endfunction

  function automatic bit exp_ready();
    int t;
    t = mode ? m_ptr : int'(sel);
    return !rst && ch_en[t];
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic cycle();
    int t;
    bit acc;
    t   = mode ? m_ptr : int'(sel);
    acc = in_valid && exp_ready();
    if (rst) begin
      for (int i = 0; i < 8; i++) m_data[i] = 8'h00;
      m_strobe = 8'h00;
      m_ptr    = 0;
      m_cnt    = 16'h0000;
    end else begin
      if (clear) for (int i = 0; i < 8; i++) m_data[i] = 8'h00;
      if (acc) m_data[t] = in_data;
      m_strobe = acc ? (8'h01 << t) : 8'h00;
      if (acc) m_cnt = m_cnt + 16'h0001;
      if (mode && acc) m_ptr = mdl_next(ch_en, t);
      else if (ch_en != 8'h00 && !ch_en[m_ptr]) m_ptr = mdl_next(ch_en, m_ptr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hC3; ch_en = 8'hFF; mode = 1'b0; sel = 3'd4;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL reset_ready: got %b want 0", in_ready);
      end
      cycle();
    end
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_data !== 64'h0 || out_strobe !== 8'h00 || cur_ch !== 3'd0 || word_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: data=%h strobe=%h cur_ch=%0d cnt=%0d want all zero",
               out_data, out_strobe, cur_ch, word_cnt);
    end
  endtask

  task automatic test_addressed();
    do_reset();
    mode = 1'b0; ch_en = 8'hFF; sel = 3'd5; in_data = 8'hA5; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_strobe !== 8'h20) begin
      errors++; $display("FAIL addr_strobe: got %h want 20", out_strobe);
    end
    checks++;
    if (out_data !== {16'h0000, 8'hA5, 40'h0}) begin
      errors++; $display("FAIL addr_data: got %h want ch5=a5 others 0", out_data);
    end
    checks++;
    if (word_cnt !== 16'd1) begin
      errors++; $display("FAIL addr_cnt: got %0d want 1", word_cnt);
    end
    cycle();
    checks++;
    if (out_strobe !== 8'h00) begin
      errors++; $display("FAIL addr_strobe_drop: got %h want 00", out_strobe);
    end
  endtask

  task automatic test_scan_wrap();
    do_reset();
    mode = 1'b1; ch_en = 8'hFF; in_valid = 1'b1;
    for (int w = 1; w <= 9; w++) begin
      in_data = 8'(w);
      cycle();
      checks++;
      if (out_strobe !== (8'h01 << ((w - 1) % 8))) begin
        errors++; $display("FAIL scan_strobe word %0d: got %h want %h", w, out_strobe, 8'h01 << ((w - 1) % 8));
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_data[i*8 +: 8] !== ((i == 0) ? 8'd9 : 8'(i + 1))) begin
        errors++; $display("FAIL scan_data ch%0d: got %h want %h", i, out_data[i*8 +: 8], (i == 0) ? 8'd9 : 8'(i + 1));
      end
    end
    checks++;
    if (cur_ch !== 3'd1 || word_cnt !== 16'd9) begin
      errors++; $display("FAIL scan_ptr_cnt: cur_ch=%0d cnt=%0d want 1 and 9", cur_ch, word_cnt);
    end
  endtask

  task automatic test_mask_skip();
    logic [7:0] words [4];
    logic [7:0] exp_s [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_s = '{8'h01, 8'h04, 8'h80, 8'h01};
    do_reset();
    mode = 1'b1; ch_en = 8'b1000_0101; in_valid = 1'b1;
    for (int w = 0; w < 4; w++) begin
      in_data = words[w];
      cycle();
      checks++;
      if (out_strobe !== exp_s[w]) begin
        errors++; $display("FAIL mask_strobe word %0d: got %h want %h", w, out_strobe, exp_s[w]);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_data !== {8'h33, 32'h0, 8'h22, 8'h00, 8'h44}) begin
      errors++; $display("FAIL mask_data: got %h", out_data);
    end
  endtask

  task automatic test_stall();
    do_reset();
    mode = 1'b0; sel = 3'd3; ch_en = 8'hF7; in_data = 8'h5A; in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ready: got %b want 0", in_ready);
      end
      cycle();
      checks++;
      if (out_strobe !== 8'h00 || word_cnt !== 16'd0) begin
        errors++; $display("FAIL stall_hold: strobe=%h cnt=%0d want 00 and 0", out_strobe, word_cnt);
      end
    end
    ch_en = 8'hFF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready);
    end
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_strobe !== 8'h08 || out_data[31:24] !== 8'h5A || word_cnt !== 16'd1) begin
      errors++; $display("FAIL stall_release: strobe=%h ch3=%h cnt=%0d want 08 5a 1", out_strobe, out_data[31:24], word_cnt);
    end
    ch_en = 8'h00; in_valid = 1'b1;
    for (int m = 0; m < 2; m++) begin
      mode = m[0];
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL empty_mask_ready mode %0d: got %b want 0", m, in_ready);
      end
      cycle();
      checks++;
      if (cur_ch !== 3'd0 || out_strobe !== 8'h00) begin
        errors++; $display("FAIL empty_mask_hold: cur_ch=%0d strobe=%h want 0 and 00", cur_ch, out_strobe);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_clear_accept();
    do_reset();
    mode = 1'b0; ch_en = 8'hFF; in_valid = 1'b1;
    for (int i = 1; i < 8; i++) begin
      sel = 3'(i); in_data = 8'(i * 17);
      cycle();
    end
    clear = 1'b1; sel = 3'd2; in_data = 8'h3C;
    cycle();
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_data !== {40'h0, 8'h3C, 16'h0000}) begin
      errors++; $display("FAIL clear_data: got %h want ch2=3c others 0", out_data);
    end
    checks++;
    if (out_strobe !== 8'h04 || word_cnt !== 16'd8) begin
      errors++; $display("FAIL clear_strobe_cnt: strobe=%h cnt=%0d want 04 and 8", out_strobe, word_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 63) == 0);
      clear    = ($urandom_range(0, 15) == 0);
      mode     = ($urandom_range(0, 3) != 0);
      sel      = 3'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       ch_en = 8'h00;
          1:       ch_en = 8'h01 << $urandom_range(0, 7);
          default: ch_en = 8'($urandom);
        endcase
      end
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_ready cyc %0d: got %b want %b", c, in_ready, exp_ready());
      end
      cycle();
      checks++;
      if (out_strobe !== m_strobe || cur_ch !== 3'(m_ptr) || word_cnt !== m_cnt) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d: strobe=%h/%h cur_ch=%0d/%0d cnt=%0d/%0d (got/want)",
                 c, out_strobe, m_strobe, cur_ch, m_ptr, word_cnt, m_cnt);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (out_data[i*8 +: 8] !== m_data[i]) begin
          errors++; $display("FAIL rand_data cyc %0d ch%0d: got %h want %h", c, i, out_data[i*8 +: 8], m_data[i]);
        end
      end
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    mode = 1'b0; sel = 3'd6; ch_en = 8'hFF; in_valid = 1'b1;
    while (m_cnt != 16'hFFFF) begin
      in_data = 8'(m_cnt);
      cycle();
    end
    checks++;
    if (word_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL cnt_max: got %h want ffff", word_cnt);
    end
    cycle();
    in_valid = 1'b0;
    checks++;
    if (word_cnt !== 16'h0000 || out_strobe !== 8'h40) begin
      errors++; $display("FAIL cnt_wrap: cnt=%h strobe=%h want 0000 and 40", word_cnt, out_strobe);
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; mode = 1'b0; sel = 3'd0; ch_en = 8'h00;
    clear = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    m_strobe = 8'h00; m_ptr = 0; m_cnt = 16'h0000;
    for (int i = 0; i < 8; i++) m_data[i] = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_addressed();
    test_scan_wrap();
    test_mask_skip();
    test_stall();
    test_clear_accept();
    test_random();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
